// File: rtl/matmul_result_drain_pkg.sv
// Shared definitions for the systolic multiplier result path: element sizes,
// drain FSM encoding and the column-major packed-index helper.
package matmul_result_drain_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BUS_WIDTH  = 16;
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int RES_W      = 2 * DATA_WIDTH;
    localparam int DIM_W      = 3;
    localparam int C_W        = MAX_DIM * MAX_DIM * RES_W;
    localparam int F_W        = MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } drain_state_e;

    // Core packs results column-major: element (r,c) lives at c*MAX_DIM+r.
    function automatic int unsigned pidx(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return int'(c) * MAX_DIM + int'(r);
    endfunction

endpackage

// File: rtl/matmul_result_drain_if.sv
// Result stream carrying one signed C element per valid/ready beat.
interface matmul_result_drain_if;
    import matmul_result_drain_pkg::*;

    logic [RES_W-1:0] res_data;
    logic [DIM_W-1:0] res_row;
    logic [DIM_W-1:0] res_col;
    logic             res_ovf;
    logic             res_last;
    logic             res_valid;
    logic             res_ready;

    modport master (output res_data, res_row, res_col, res_ovf, res_last, res_valid,
                    input  res_ready);
    modport slave  (input  res_data, res_row, res_col, res_ovf, res_last, res_valid,
                    output res_ready);
endinterface

// File: rtl/matmul_drain_counter.sv
// Row-major (row,col) walker over the captured N x M region; dimensions are
// clamped to MAX_DIM when loaded.
module matmul_drain_counter
    import matmul_result_drain_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] n_raw_i,
    input  logic [DIM_W-1:0] m_raw_i,
    output logic [DIM_W-1:0] n_cl_o,
    output logic [DIM_W-1:0] m_cl_o,
    output logic [DIM_W-1:0] row_nxt_o,
    output logic [DIM_W-1:0] col_nxt_o,
    output logic             last_nxt_o
);

    logic [DIM_W-1:0] row_q, col_q, n_q, m_q;

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        if (int'(d) > MAX_DIM) begin
            return DIM_W'(MAX_DIM);
        end else begin
            return d;
        end
    endfunction

    assign n_cl_o = clamp_dim(n_raw_i);
    assign m_cl_o = clamp_dim(m_raw_i);

    // Next position with wrap at the last column.
    always_comb begin
        row_nxt_o = row_q;
        col_nxt_o = col_q;
        if (col_q == m_q - 3'd1) begin
            col_nxt_o = 3'd0;
            row_nxt_o = row_q + 3'd1;
        end else begin
            col_nxt_o = col_q + 3'd1;
        end
        last_nxt_o = (row_nxt_o == n_q - 3'd1) && (col_nxt_o == m_q - 3'd1);
    end

    // Position and dimension registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
            n_q   <= 3'd0;
            m_q   <= 3'd0;
        end else if (load_i) begin
            row_q <= 3'd0;
            col_q <= 3'd0;
            n_q   <= n_cl_o;
            m_q   <= m_cl_o;
        end else if (adv_i) begin
            row_q <= row_nxt_o;
            col_q <= col_nxt_o;
        end else begin
            row_q <= row_q;
            col_q <= col_q;
        end
    end

endmodule

// File: rtl/matmul_result_drain.sv
// Snapshots the multiplier result on each completion edge and streams the
// N x M elements out row-major, one per accepted beat.
module matmul_result_drain
    import matmul_result_drain_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    finish_mul_i,
    input  logic [C_W-1:0]          c_matrix_i,
    input  logic [F_W-1:0]          flags_i,
    input  logic [DIM_W-1:0]        n_dim_i,
    input  logic [DIM_W-1:0]        m_dim_i,
    matmul_result_drain_if.master   res_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ovf_any_o,
    output logic                    overrun_o
);

    drain_state_e     state_q;
    logic             finish_q;
    logic [C_W-1:0]   snap_data_q;
    logic [F_W-1:0]   snap_flags_q;
    logic [RES_W-1:0] data_q;
    logic [DIM_W-1:0] row_q, col_q;
    logic             ovf_q, last_q, valid_q, busy_q, done_q, ovf_any_q, overrun_q;

    logic             cap_s, load_s, hs_s, ovf_mask_s, last_nxt_s;
    logic [DIM_W-1:0] n_cl_s, m_cl_s, row_nxt_s, col_nxt_s;

    assign cap_s  = finish_mul_i & ~finish_q;
    assign load_s = cap_s && (state_q == S_IDLE);
    assign hs_s   = valid_q & res_if.res_ready;

    matmul_drain_counter u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load_s),
        .adv_i      (hs_s),
        .n_raw_i    (n_dim_i),
        .m_raw_i    (m_dim_i),
        .n_cl_o     (n_cl_s),
        .m_cl_o     (m_cl_s),
        .row_nxt_o  (row_nxt_s),
        .col_nxt_o  (col_nxt_s),
        .last_nxt_o (last_nxt_s)
    );

    // Overflow summary restricted to the requested N x M window.
    always_comb begin
        ovf_mask_s = 1'b0;
        for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
                if ((r < int'(n_cl_s)) && (c < int'(m_cl_s))) begin
                    ovf_mask_s = ovf_mask_s | flags_i[pidx(DIM_W'(r), DIM_W'(c))];
                end else begin
                    ovf_mask_s = ovf_mask_s;
                end
            end
        end
    end

    // Drain FSM with snapshot and registered stream outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            finish_q     <= 1'b0;
            snap_data_q  <= '0;
            snap_flags_q <= '0;
            data_q       <= '0;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            ovf_q        <= 1'b0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_any_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            finish_q  <= finish_mul_i;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cap_s) begin
                        snap_data_q  <= c_matrix_i;
                        snap_flags_q <= flags_i;
                        ovf_any_q    <= ovf_mask_s;
                        if ((n_cl_s == 3'd0) || (m_cl_s == 3'd0)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_STREAM;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            data_q  <= c_matrix_i[RES_W-1:0];
                            ovf_q   <= flags_i[0];
                            row_q   <= 3'd0;
                            col_q   <= 3'd0;
                            last_q  <= (n_cl_s == 3'd1) && (m_cl_s == 3'd1);
                        end
                    end
                end
                S_STREAM: begin
                    overrun_q <= cap_s;
                    if (hs_s) begin
                        if (last_q) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= '0;
                            row_q   <= 3'd0;
                            col_q   <= 3'd0;
                            ovf_q   <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            data_q <= snap_data_q[pidx(row_nxt_s, col_nxt_s)*RES_W +: RES_W];
                            ovf_q  <= snap_flags_q[pidx(row_nxt_s, col_nxt_s)];
                            row_q  <= row_nxt_s;
                            col_q  <= col_nxt_s;
                            last_q <= last_nxt_s;
                        end
                    end
                end
                S_DONE: begin
                    overrun_q <= cap_s;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign res_if.res_data  = data_q;
    assign res_if.res_row   = row_q;
    assign res_if.res_col   = col_q;
    assign res_if.res_ovf   = ovf_q;
    assign res_if.res_last  = last_q;
    assign res_if.res_valid = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign ovf_any_o        = ovf_any_q;
    assign overrun_o        = overrun_q;

endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed bench for matmul_result_drain: beat order, stalls, clamping-free
// small shapes, overflow flags, overrun and async reset mid-stream.
module tb_matmul_result_drain;
    import matmul_result_drain_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             finish_mul_i = 1'b0;
    logic [C_W-1:0]   c_matrix_i = '0;
    logic [F_W-1:0]   flags_i = '0;
    logic [DIM_W-1:0] n_dim_i = 3'd0;
    logic [DIM_W-1:0] m_dim_i = 3'd0;
    logic             busy_o, done_o, ovf_any_o, overrun_o;

    int n_pass = 0;
    int n_chk  = 0;

    logic [15:0] exp_d [4];
    logic [2:0]  exp_r [4];
    logic [2:0]  exp_c [4];
    logic        exp_o [4];

    matmul_result_drain_if u_if ();

    matmul_result_drain dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .finish_mul_i (finish_mul_i),
        .c_matrix_i   (c_matrix_i),
        .flags_i      (flags_i),
        .n_dim_i      (n_dim_i),
        .m_dim_i      (m_dim_i),
        .res_if       (u_if.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ovf_any_o    (ovf_any_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_2x2_beats(input logic [3:0] ovf);
        exp_d[0] = 16'd1; exp_r[0] = 3'd0; exp_c[0] = 3'd0; exp_o[0] = ovf[0];
        exp_d[1] = 16'd2; exp_r[1] = 3'd0; exp_c[1] = 3'd1; exp_o[1] = ovf[1];
        exp_d[2] = 16'd3; exp_r[2] = 3'd1; exp_c[2] = 3'd0; exp_o[2] = ovf[2];
        exp_d[3] = 16'd4; exp_r[3] = 3'd1; exp_c[3] = 3'd1; exp_o[3] = ovf[3];
    endtask

    // Collects nbeats beats with ready cycling through pat, then checks done.
    task automatic run_drain(input int nbeats, input logic [3:0] pat);
        int k = 0;
        int cyc = 0;
        while (k < nbeats && cyc < 40) begin
            @(negedge clk_i);
            chk("valid", u_if.res_valid, 1'b1);
            chk("data",  u_if.res_data, exp_d[k]);
            chk("row",   u_if.res_row,  exp_r[k]);
            chk("col",   u_if.res_col,  exp_c[k]);
            chk("ovf",   u_if.res_ovf,  exp_o[k]);
            chk("last",  u_if.res_last, (k == nbeats - 1));
            chk("busy",  busy_o, 1'b1);
            u_if.res_ready = pat[cyc % 4];
            if (u_if.res_ready) k++;
            cyc++;
        end
        chk("beat_count", k, nbeats);
        @(negedge clk_i);
        chk("done_pulse", done_o, 1'b1);
        chk("valid_after", u_if.res_valid, 1'b0);
        chk("busy_after", busy_o, 1'b0);
        @(negedge clk_i);
        chk("done_clear", done_o, 1'b0);
        chk("no_extra_beat", u_if.res_valid, 1'b0);
    endtask

    initial begin
        u_if.res_ready = 1'b0;
        #12;
        chk("rst_valid", u_if.res_valid, 1'b0);
        chk("rst_data", u_if.res_data, 16'h0000);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_ovf_any", ovf_any_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 2x2, ready high
        c_matrix_i = 64'h0004_0002_0003_0001;
        n_dim_i = 3'd2; m_dim_i = 3'd2; flags_i = 4'b0000;
        set_2x2_beats(4'b0000);
        finish_mul_i = 1'b1;
        run_drain(4, 4'b1111);
        finish_mul_i = 1'b0;
        @(negedge clk_i);

        // same input with stalls
        finish_mul_i = 1'b1;
        run_drain(4, 4'b1001);
        finish_mul_i = 1'b0;
        @(negedge clk_i);

        // 1x2 with signed values
        c_matrix_i = 64'h0000_012C_0000_FFFB;
        n_dim_i = 3'd1; m_dim_i = 3'd2;
        exp_d[0] = 16'hFFFB; exp_r[0] = 3'd0; exp_c[0] = 3'd0; exp_o[0] = 1'b0;
        exp_d[1] = 16'h012C; exp_r[1] = 3'd0; exp_c[1] = 3'd1; exp_o[1] = 1'b0;
        finish_mul_i = 1'b1;
        run_drain(2, 4'b1111);
        finish_mul_i = 1'b0;
        @(negedge clk_i);

        // N=0: no beats, immediate done
        n_dim_i = 3'd0;
        finish_mul_i = 1'b1;
        @(negedge clk_i);
        chk("n0_done", done_o, 1'b1);
        chk("n0_valid", u_if.res_valid, 1'b0);
        chk("n0_busy", busy_o, 1'b0);
        @(negedge clk_i);
        chk("n0_done_clear", done_o, 1'b0);
        finish_mul_i = 1'b0;
        @(negedge clk_i);

        // overflow on (1,1)
        c_matrix_i = 64'h0004_0002_0003_0001;
        n_dim_i = 3'd2; m_dim_i = 3'd2; flags_i = 4'b1000;
        set_2x2_beats(4'b1000);
        finish_mul_i = 1'b1;
        run_drain(4, 4'b1111);
        chk("ovf_any_2x2", ovf_any_o, 1'b1);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        n_dim_i = 3'd1; m_dim_i = 3'd1;
        finish_mul_i = 1'b1;
        run_drain(1, 4'b1111);
        chk("ovf_any_1x1", ovf_any_o, 1'b0);
        finish_mul_i = 1'b0;
        @(negedge clk_i);

        // held completion, then second edge mid-stream
        n_dim_i = 3'd2; m_dim_i = 3'd2; flags_i = 4'b0000;
        set_2x2_beats(4'b0000);
        u_if.res_ready = 1'b0;
        finish_mul_i = 1'b1;
        repeat (10) @(negedge clk_i);
        chk("hold_overrun", overrun_o, 1'b0);
        chk("hold_data", u_if.res_data, 16'd1);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        finish_mul_i = 1'b1;
        c_matrix_i = 64'h0099_0088_0077_0066;
        n_dim_i = 3'd1;
        @(negedge clk_i);
        chk("overrun_pulse", overrun_o, 1'b1);
        chk("overrun_data", u_if.res_data, 16'd1);
        @(negedge clk_i);
        chk("overrun_clear", overrun_o, 1'b0);
        finish_mul_i = 1'b0;
        run_drain(4, 4'b1111);

        // async reset mid-stream
        c_matrix_i = 64'h0004_0002_0003_0001;
        n_dim_i = 3'd2; m_dim_i = 3'd2;
        u_if.res_ready = 1'b1;
        finish_mul_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("pre_rst_data", u_if.res_data, 16'd3);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", u_if.res_valid, 1'b0);
        chk("arst_data", u_if.res_data, 16'h0000);
        chk("arst_busy", busy_o, 1'b0);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        chk("arst_done", done_o, 1'b0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_idle", u_if.res_valid, 1'b0);
        finish_mul_i = 1'b1;
        run_drain(4, 4'b1111);
        finish_mul_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
